// File: rtl/pc_unit.sv
// Program-counter stage: resolves branch/jump conditions from the ALU flags,
// selects and registers the next PC, and tracks run/halt/trap state plus retired count.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic             Halt,
  input  logic [2:0]       BranchType,
  input  logic [1:0]       JumpType,
  input  logic             Zero,
  input  logic             Sign,
  input  logic [31:0]      Imm32,
  input  logic [25:0]      JumpAddr,
  input  logic [31:0]      RegAddr,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic [31:0]      NextPC,
  output logic             Taken,
  output logic             Halted,
  output logic             Trap,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_TRAP = 2'b10
  } state_t;

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLTZ = 3'b011;
  localparam logic [2:0] BR_BGEZ = 3'b100;
  localparam logic [2:0] BR_BGTZ = 3'b101;
  localparam logic [2:0] BR_BLEZ = 3'b110;

  localparam logic [1:0] JT_J  = 2'b01;
  localparam logic [1:0] JT_JR = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [31:0]      pc, pc_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] sel_pc;
  logic        sel_taken;
  logic        branch_cond;
  logic        jump_sel;
  logic        jr_misaligned;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + (Imm32 << 2);
  assign jump_sel      = (JumpType == JT_J) || (JumpType == JT_JR);
  assign jr_misaligned = (JumpType == JT_JR) && (RegAddr[1:0] != 2'b00);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    branch_cond = 1'b0;
    unique case (BranchType)
      BR_BEQ:  branch_cond = Zero;
      BR_BNE:  branch_cond = !Zero;
      BR_BLTZ: branch_cond = Sign;
      BR_BGEZ: branch_cond = !Sign;
      BR_BGTZ: branch_cond = !Sign && !Zero;
      BR_BLEZ: branch_cond = Sign || Zero;
      default: branch_cond = 1'b0;
    endcase
  end

  always_comb begin
    jump_target = RegAddr;
    if (JumpType == JT_J) jump_target = {pc_plus4[31:28], JumpAddr, 2'b00};
  end

  // Halt outranks jumps, jumps outrank branches; outside RUN the PC is pinned.
  always_comb begin
    sel_pc    = pc_plus4;
    sel_taken = 1'b0;
    if (state != ST_RUN || Halt) begin
      sel_pc    = pc;
      sel_taken = 1'b0;
    end else if (jump_sel) begin
      sel_pc    = jump_target;
      sel_taken = 1'b1;
    end else if (branch_cond) begin
      sel_pc    = branch_target;
      sel_taken = 1'b1;
    end
  end

  // A misaligned JR traps without retiring; Halt on the same edge wins.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cnt;
    if (PCWre) begin
      unique case (state)
        ST_RUN: begin
          if (Halt) begin
            state_next = ST_HALT;
            cnt_next   = cnt + CNT_ONE;
          end else if (jr_misaligned) begin
            state_next = ST_TRAP;
          end else begin
            pc_next  = sel_pc;
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      cnt   <= cnt_next;
    end
  end

  assign PC         = pc;
  assign PCPlus4    = pc_plus4;
  assign NextPC     = sel_pc;
  assign Taken      = sel_taken;
  assign Halted     = (state == ST_HALT);
  assign Trap       = (state == ST_TRAP);
  assign InstrCount = cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the program-counter rules.
module tb_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_TRAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_we = 1'b0;
  logic        halt = 1'b0;
  logic [2:0]  btype = '0;
  logic [1:0]  jtype = '0;
  logic        zero = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] imm = '0;
  logic [25:0] jaddr = '0;
  logic [31:0] raddr = '0;

  logic [31:0] pc, pc_plus4, next_pc, instr_count;
  logic        taken, halted, trap;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_mode;

  pc_unit #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .CLK(clk), .Reset(rst), .PCWre(pc_we), .Halt(halt), .BranchType(btype),
    .JumpType(jtype), .Zero(zero), .Sign(sign), .Imm32(imm), .JumpAddr(jaddr),
    .RegAddr(raddr), .PC(pc), .PCPlus4(pc_plus4), .NextPC(next_pc), .Taken(taken),
    .Halted(halted), .Trap(trap), .InstrCount(instr_count)
  );

  always #5 clk = ~clk;

  // Reference: the ALU result is negative, zero or positive; each branch asks about that class.
  function automatic void ref_comb(output logic [31:0] npc, output logic tk);
    logic [31:0] seq;
    bit neg, zer, pos, cond;
    seq = m_pc + 32'd4;
    neg = sign;
    zer = zero;
    pos = !sign && !zero;
    npc = seq;
    tk  = 1'b0;
    if (m_mode != M_RUN || halt) begin
      npc = m_pc;
    end else if (jtype == 2'd1) begin
      npc = (seq & 32'hF000_0000) + ({6'd0, jaddr} * 4);
      tk  = 1'b1;
    end else if (jtype == 2'd2) begin
      npc = raddr;
      tk  = 1'b1;
    end else begin
      case (btype)
        3'd1:    cond = zer;
        3'd2:    cond = !zer;
        3'd3:    cond = neg;
        3'd4:    cond = !neg;
        3'd5:    cond = pos;
        3'd6:    cond = !pos;
        default: cond = 1'b0;
      endcase
      if (cond) begin
        npc = seq + imm * 4;
        tk  = 1'b1;
      end
    end
  endfunction

  // Advance the model for one rising edge using the inputs currently applied, then wait for it.
  task automatic tick();
    logic [31:0] npc;
    logic tk;
    ref_comb(npc, tk);
    if (pc_we && m_mode == M_RUN) begin
      if (halt) begin
        m_mode = M_HALT;
        m_cnt  = m_cnt + 1;
      end else if (jtype == 2'd2 && (raddr % 4) != 0) begin
        m_mode = M_TRAP;
      end else begin
        m_pc  = npc;
        m_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_we = 1'b1; halt = 1'b0; btype = '0; jtype = '0;
    zero = 1'b0; sign = 1'b0; imm = '0; jaddr = '0; raddr = '0;
  endtask

  // Asserted mid-cycle and released before the next edge.
  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    m_pc = RESET_PC; m_cnt = 0; m_mode = M_RUN;
    checks += 4;
    if (pc !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
    if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", instr_count); end
    if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    if (trap !== 1'b0) begin failures++; $display("FAIL reset_trap got=%b exp=0", trap); end
    #1;
    rst = 1'b1;
    idle_inputs();
  endtask

  task automatic set_pc(input logic [31:0] addr);
    idle_inputs();
    jtype = 2'd2;
    raddr = addr;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #3;
    m_pc = RESET_PC; m_cnt = 0; m_mode = M_RUN;
    checks += 4;
    if (pc !== RESET_PC) begin failures++; $display("FAIL por_pc got=%h exp=%h", pc, RESET_PC); end
    if (instr_count !== 32'd0) begin failures++; $display("FAIL por_cnt got=%0d exp=0", instr_count); end
    if (halted !== 1'b0 || trap !== 1'b0) begin
      failures++; $display("FAIL por_flags got=%b%b exp=00", halted, trap);
    end
    if (pc_plus4 !== RESET_PC + 32'd4) begin failures++; $display("FAIL por_pcplus4 got=%h", pc_plus4); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (taken !== 1'b0) begin failures++; $display("FAIL seq_taken got=%b exp=0", taken); end
      tick();
      checks++;
      if (pc !== 32'(4 * i)) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'(4 * i)); end
    end
    checks++;
    if (instr_count !== 32'd3) begin failures++; $display("FAIL seq_cnt got=%0d exp=3", instr_count); end
    set_pc(32'hFFFF_FFFC);
    checks++;
    if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pcplus4 got=%h exp=0", pc_plus4); end
    tick();
    checks++;
    if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
  endtask

  task automatic test_beq();
    set_pc(32'h10);
    btype = 3'd1; zero = 1'b1; imm = 32'hFFFF_FFFE;
    #1;
    checks += 2;
    if (taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", taken); end
    if (next_pc !== 32'h0C) begin failures++; $display("FAIL beq_nextpc got=%h exp=0000000c", next_pc); end
    tick();
    checks++;
    if (pc !== 32'h0C) begin failures++; $display("FAIL beq_pc got=%h exp=0000000c", pc); end
    set_pc(32'h10);
    btype = 3'd1; zero = 1'b0; imm = 32'hFFFF_FFFE;
    tick();
    checks++;
    if (pc !== 32'h14) begin failures++; $display("FAIL beq_nt_pc got=%h exp=00000014", pc); end
  endtask

  task automatic test_bgtz_blez();
    // Expected PCs written out per {Zero,Sign}: 00, 01, 10.
    logic [31:0] exp_bgtz [3] = '{32'h110, 32'h104, 32'h104};
    logic [31:0] exp_blez [3] = '{32'h104, 32'h110, 32'h110};
    logic [1:0]  zs [3] = '{2'b00, 2'b01, 2'b10};
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 3; k++) begin
        set_pc(32'h100);
        btype = (t == 0) ? 3'd5 : 3'd6;
        {zero, sign} = zs[k];
        imm = 32'd3;
        tick();
        checks++;
        if (pc !== ((t == 0) ? exp_bgtz[k] : exp_blez[k])) begin
          failures++;
          $display("FAIL %s_zs%b got=%h exp=%h", (t == 0) ? "bgtz" : "blez", zs[k], pc,
                   (t == 0) ? exp_bgtz[k] : exp_blez[k]);
        end
      end
    end
  endtask

  task automatic test_jump_trap();
    logic [31:0] cnt_before;
    set_pc(32'h4000_0000);
    jtype = 2'd1; jaddr = 26'h000_0010;
    tick();
    checks++;
    if (pc !== 32'h4000_0040) begin failures++; $display("FAIL j_pc got=%h exp=40000040", pc); end
    cnt_before = m_cnt;
    jtype = 2'd2; raddr = 32'h2002;
    tick();
    checks += 3;
    if (trap !== 1'b1) begin failures++; $display("FAIL jr_trap got=%b exp=1", trap); end
    if (pc !== 32'h4000_0040) begin failures++; $display("FAIL jr_trap_pc got=%h exp=40000040", pc); end
    if (instr_count !== cnt_before) begin
      failures++; $display("FAIL jr_trap_cnt got=%0d exp=%0d", instr_count, cnt_before);
    end
    for (int i = 0; i < 4; i++) begin
      btype = 3'($urandom); jtype = 2'($urandom); zero = 1'($urandom); sign = 1'($urandom);
      imm = $urandom; raddr = $urandom;
      #1;
      checks += 2;
      if (next_pc !== 32'h4000_0040 || taken !== 1'b0) begin
        failures++; $display("FAIL trap_comb nextpc=%h taken=%b exp=40000040/0", next_pc, taken);
      end
      tick();
      if (pc !== 32'h4000_0040 || instr_count !== cnt_before || trap !== 1'b1) begin
        failures++;
        $display("FAIL trap_frozen pc=%h cnt=%0d trap=%b exp=40000040/%0d/1", pc, instr_count, trap, cnt_before);
      end
    end
    pulse_reset();
  endtask

  task automatic test_halt();
    tick();
    tick();
    pc_we = 1'b0; halt = 1'b1; jtype = 2'd2; raddr = 32'h3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h8 || instr_count !== 32'd2 || halted !== 1'b0 || trap !== 1'b0) begin
        failures++;
        $display("FAIL wre0_hold pc=%h cnt=%0d h=%b t=%b exp=00000008/2/0/0", pc, instr_count, halted, trap);
      end
    end
    pc_we = 1'b1;
    tick();
    checks += 4;
    if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
    if (trap !== 1'b0) begin failures++; $display("FAIL halt_trap got=%b exp=0", trap); end
    if (instr_count !== 32'd3) begin failures++; $display("FAIL halt_cnt got=%0d exp=3", instr_count); end
    if (pc !== 32'h8) begin failures++; $display("FAIL halt_pc got=%h exp=00000008", pc); end
    halt = 1'b0; jtype = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_count !== 32'd3 || pc !== 32'h8) begin
        failures++; $display("FAIL halt_frozen pc=%h cnt=%0d exp=00000008/3", pc, instr_count);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    set_pc(32'h80);
    halt = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 32'h80) begin
      failures++; $display("FAIL pre_reset_halt h=%b pc=%h exp=1/00000080", halted, pc);
    end
    pulse_reset();
  endtask

  task automatic test_random();
    logic [31:0] npc;
    logic tk;
    int stuck = 0;
    for (int n = 0; n < 400; n++) begin
      pc_we = ($urandom_range(0, 9) < 8);
      halt  = ($urandom_range(0, 49) == 0);
      btype = 3'($urandom);
      jtype = 2'($urandom);
      zero  = 1'($urandom);
      sign  = 1'($urandom);
      imm   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
      jaddr = 26'($urandom);
      raddr = $urandom;
      if ($urandom_range(0, 19) != 0) raddr[1:0] = 2'b00;
      #1;
      ref_comb(npc, tk);
      checks += 3;
      if (next_pc !== npc) begin failures++; $display("FAIL rnd_nextpc n=%0d got=%h exp=%h", n, next_pc, npc); end
      if (taken !== tk) begin failures++; $display("FAIL rnd_taken n=%0d got=%b exp=%b", n, taken, tk); end
      if (pc_plus4 !== m_pc + 32'd4) begin
        failures++; $display("FAIL rnd_pcplus4 n=%0d got=%h exp=%h", n, pc_plus4, m_pc + 32'd4);
      end
      tick();
      checks += 4;
      if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, m_pc); end
      if (instr_count !== m_cnt) begin
        failures++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, instr_count, m_cnt);
      end
      if (halted !== (m_mode == M_HALT)) begin failures++; $display("FAIL rnd_halted n=%0d got=%b", n, halted); end
      if (trap !== (m_mode == M_TRAP)) begin failures++; $display("FAIL rnd_trap n=%0d got=%b", n, trap); end
      stuck = (m_mode != M_RUN) ? stuck + 1 : 0;
      if (stuck > 3) begin
        pulse_reset();
        stuck = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_bgtz_blez();
    test_jump_trap();
    test_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly downstream of the execute ALU.
- Consumes the ALU Zero/Sign flags, resolves branch and jump conditions, selects the next PC and registers it.
- Feeds instruction fetch (PC) and the link/datapath (PCPlus4).
- Run/halt/trap state machine; retired-instruction counter for bench and debug visibility.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned.
CNT_W, 32, width of retired-instruction counter.

Ports:
CLK  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
PCWre  input  1  PC write enable from control; PC advances only on edges where PCWre=1.
Halt  input  1  halt instruction decoded this cycle.
BranchType  input  3  000 none, 001 BEQ, 010 BNE, 011 BLTZ, 100 BGEZ, 101 BGTZ, 110 BLEZ, 111 reserved (treated as none).
JumpType  input  2  00 sequential/branch, 01 J/JAL (26-bit target), 10 JR (register target), 11 reserved (treated as 00).
Zero  input  1  ALU Result==0 flag.
Sign  input  1  ALU Result[31].
Imm32  input  32  sign-extended branch word offset.
JumpAddr  input  26  J-format target field.
RegAddr  input  32  register value for JR.
PC  output  32  current PC (registered).
PCPlus4  output  32  PC+4, combinational.
NextPC  output  32  selected next PC, combinational.
Taken  output  1  non-sequential target selected this cycle, combinational.
Halted  output  1  state==HALT.
Trap  output  1  state==TRAP.
InstrCount  output  CNT_W  count of PC updates performed.

Behaviour:
- Reset (Reset=0, asynchronous): PC=RESET_PC, state=RUN, InstrCount=0, Halted=0, Trap=0. Takes effect mid-cycle regardless of PCWre. The first rising edge after deassertion is a normal RUN edge.
- PCPlus4 = PC+32'd4, modulo 2^32 (FFFFFFFC wraps to 00000000).
- Branch condition:
  - BEQ: Zero. BNE: !Zero.
  - BLTZ: Sign. BGEZ: !Sign.
  - BGTZ: !Sign && !Zero. BLEZ: Sign || Zero.
- Branch target = PCPlus4 + (Imm32<<2), 32-bit wrap, carry discarded.
- J target = {PCPlus4[31:28], JumpAddr, 2'b00}.
- JR target = RegAddr.
- Next-PC priority, combinational:
  1. Halt → NextPC=PC, Taken=0.
  2. JumpType 01/10 → jump target, Taken=1.
  3. Branch condition true → branch target, Taken=1.
  4. Otherwise → PCPlus4, Taken=0.
- Taken and NextPC are forced to PC/0 when state != RUN.
- State machine (registered, transitions on rising CLK with PCWre=1 only):
  - RUN, Halt=1 → HALT. PC unchanged, InstrCount+1 (the halt instruction retires).
  - RUN, JumpType=10 with RegAddr[1:0]!=0 → TRAP. PC unchanged, InstrCount unchanged.
  - RUN, otherwise → RUN. PC<=NextPC, InstrCount+1.
  - HALT, TRAP: absorbing; PC and InstrCount frozen; exit only via Reset.
- PCWre=0: no state, PC or counter change in any state; combinational outputs still track inputs.
- Halt and misaligned JR on the same edge: Halt wins (HALT, not TRAP).
- Misaligned branch/J targets are impossible by construction; no check.
- InstrCount wraps to 0 after all-ones; no saturation.
- Single PC register update per edge; no additional latency.

Test Plan:
- Reset=0 then release, PCWre=1, BranchType=000, JumpType=00 for 3 edges → PC 0,4,8,C; InstrCount=3; Taken=0.
- PC=0x10, BranchType=001, Zero=1, Imm32=0xFFFFFFFE → Taken=1, NextPC=0x0C; next edge PC=0x0C. Repeat with Zero=0 → PC=0x14.
- BGTZ/BLEZ sweep over {Zero,Sign} ∈ {00,01,10}, Imm32=3, PC=0x100 → BGTZ taken only for 00 (PC=0x110); BLEZ taken for 01 and 10.
- PC=0x40000000, JumpType=01, JumpAddr=0x0000010 → PC=0x40000040. JumpType=10, RegAddr=0x2002 → TRAP=1, PC stays 0x40000040, further edges frozen.
- Halt=1 together with JumpType=10, RegAddr=0x3 → Halted=1, Trap=0, InstrCount increments once then freezes. PCWre=0 edges beforehand → no change.
- Assert Reset=0 asynchronously between edges while HALTED at PC=0x80 → PC=RESET_PC, Halted=0, InstrCount=0 immediately, before the next edge.
